// File: rtl/uart_cmd_seq_if.sv
// uart_cmd_seq_if: groups the receiver-side and decoder-side handshakes of the
// UART command sequencer.
//   rx_data     [7:0]  byte from the UART receiver, valid while rx_rdy=1
//   rx_rdy             receiver byte-available level flag
//   clr_rdy            one-cycle clear back to the receiver's rdy flag
//   cmd         [23:0] assembled command {opcode, data_hi, data_lo}
//   cmd_rdy            command valid, held until clr_cmd_rdy
//   clr_cmd_rdy        decoder acknowledge
//   to_err             one-cycle pulse: partial frame dropped on timeout
//   chk_err            one-cycle pulse: checksum mismatch
// Modports: master = environment (receiver + decoder), slave = sequencer.
interface uart_cmd_seq_if;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        to_err;
  logic        chk_err;

  modport master (
    output rx_data,
    output rx_rdy,
    output clr_cmd_rdy,
    input  clr_rdy,
    input  cmd,
    input  cmd_rdy,
    input  to_err,
    input  chk_err
  );

  modport slave (
    input  rx_data,
    input  rx_rdy,
    input  clr_cmd_rdy,
    output clr_rdy,
    output cmd,
    output cmd_rdy,
    output to_err,
    output chk_err
  );
endinterface

// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: assembles UART receive bytes into fixed-length commands
// {opcode, data_hi, data_lo} and hands them to the command decoder.
// Partial frames are dropped after TIMEOUT_CLKS idle clocks between bytes;
// while a command is pending the receiver is back-pressured (clr_rdy held 0).
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    uart_cmd_seq_if.slave (rx_data/rx_rdy/clr_rdy, cmd/cmd_rdy/clr_cmd_rdy,
//          to_err, chk_err)
//
// Optional feature: define UART_CMD_CHECKSUM_EN to use 4-byte frames whose last
// byte must equal ~(b0+b1+b2); a mismatch drops the frame and pulses chk_err.
// Without it frames are 3 bytes and chk_err is tied low.
module uart_cmd_seq #(
  parameter int unsigned TIMEOUT_CLKS = 4096,
  parameter int unsigned TO_W         = $clog2(TIMEOUT_CLKS)
) (
  input logic           clk,
  input logic           rst_n,
  uart_cmd_seq_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StHold    = 2'd2
  } state_e;

  // Byte index of the final byte of a frame (count of bytes already taken).
`ifdef UART_CMD_CHECKSUM_EN
  localparam logic [1:0] LastIdx = 2'd3;
`else
  localparam logic [1:0] LastIdx = 2'd2;
`endif

  localparam logic [TO_W-1:0] ToMax = TO_W'(TIMEOUT_CLKS - 1);

  state_e          r_state;
  logic [1:0]      r_byte_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic [23:0]     r_frame;
  logic [23:0]     r_cmd;
  logic            r_cmd_rdy;
  logic            r_to_err;

  state_e          w_state_nxt;
  logic [1:0]      w_byte_cnt_nxt;
  logic [TO_W-1:0] w_to_cnt_nxt;
  logic [23:0]     w_frame_nxt;
  logic [23:0]     w_cmd_nxt;
  logic            w_cmd_rdy_nxt;
  logic            w_to_err_nxt;
  logic            w_accept;
  logic            w_shift;

`ifdef UART_CMD_CHECKSUM_EN
  logic            r_chk_err;
  logic            w_chk_err_nxt;
  logic [7:0]      w_sum;

  assign w_sum = r_frame[23:16] + r_frame[15:8] + r_frame[7:0];
`endif

  // Gated by rst_n so the receiver's flag is never cleared while in reset.
  assign w_accept = rst_n && bus.rx_rdy && ((r_state == StIdle) || (r_state == StCollect));

  // The checksum byte is only compared, never stored in the frame.
  assign w_shift  = w_accept && (r_byte_cnt != 2'd3);

  always_comb begin
    w_state_nxt    = r_state;
    w_byte_cnt_nxt = r_byte_cnt;
    w_to_cnt_nxt   = r_to_cnt;
    w_frame_nxt    = r_frame;
    w_cmd_nxt      = r_cmd;
    w_cmd_rdy_nxt  = r_cmd_rdy;
    w_to_err_nxt   = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    w_chk_err_nxt  = 1'b0;
`endif

    if (w_shift) begin
      w_frame_nxt = {r_frame[15:0], bus.rx_data};
    end

    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_byte_cnt_nxt = 2'd1;
          w_to_cnt_nxt   = '0;
          w_state_nxt    = StCollect;
        end
      end

      StCollect: begin
        if (w_accept) begin
          // An accept always wins over a timeout in the same cycle.
          w_to_cnt_nxt = '0;
          if (r_byte_cnt == LastIdx) begin
            w_byte_cnt_nxt = 2'd0;
`ifdef UART_CMD_CHECKSUM_EN
            if (bus.rx_data == ~w_sum) begin
              w_cmd_nxt     = r_frame;
              w_cmd_rdy_nxt = 1'b1;
              w_state_nxt   = StHold;
            end else begin
              w_chk_err_nxt = 1'b1;
              w_state_nxt   = StIdle;
            end
`else
            w_cmd_nxt     = w_frame_nxt;
            w_cmd_rdy_nxt = 1'b1;
            w_state_nxt   = StHold;
`endif
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          end
        end else if (r_to_cnt == ToMax) begin
          w_state_nxt    = StIdle;
          w_byte_cnt_nxt = 2'd0;
          w_to_cnt_nxt   = '0;
          w_to_err_nxt   = 1'b1;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
      end

      StHold: begin
        if (bus.clr_cmd_rdy) begin
          w_cmd_rdy_nxt = 1'b0;
          w_state_nxt   = StIdle;
        end
      end

      default: begin
        w_state_nxt    = StIdle;
        w_byte_cnt_nxt = 2'd0;
        w_to_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_byte_cnt <= 2'd0;
      r_to_cnt   <= '0;
      r_frame    <= 24'h0;
      r_cmd      <= 24'h0;
      r_cmd_rdy  <= 1'b0;
      r_to_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_frame    <= w_frame_nxt;
      r_cmd      <= w_cmd_nxt;
      r_cmd_rdy  <= w_cmd_rdy_nxt;
      r_to_err   <= w_to_err_nxt;
    end
  end

`ifdef UART_CMD_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk_err <= 1'b0;
    end else begin
      r_chk_err <= w_chk_err_nxt;
    end
  end

  assign bus.chk_err = r_chk_err;
`else
  assign bus.chk_err = 1'b0;
`endif

  assign bus.clr_rdy = w_accept;
  assign bus.cmd     = r_cmd;
  assign bus.cmd_rdy = r_cmd_rdy;
  assign bus.to_err  = r_to_err;

endmodule

// File: tb/tb_uart_cmd_seq.sv
// tb_uart_cmd_seq: directed bench for uart_cmd_seq. Inputs change 1ns after the
// rising edge; outputs are checked 3ns after the edge, pulse monitors sample on
// the falling edge.
module tb_uart_cmd_seq;

  localparam int unsigned TimeoutClks = 4096;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  uart_cmd_seq_if bus ();

  uart_cmd_seq #(
    .TIMEOUT_CLKS(TimeoutClks)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_clr    = 0;
  int n_to     = 0;
  int n_chk    = 0;
  int last_wait;

  always @(negedge clk) begin
    if (bus.clr_rdy === 1'b1) n_clr++;
    if (bus.to_err === 1'b1) n_to++;
    if (bus.chk_err === 1'b1) n_chk++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Receiver model: present a byte, wait for clr_rdy, drop rdy after that edge.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited      = 0;
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    #2;
    while (bus.clr_rdy !== 1'b1 && waited < 20000) begin
      @(posedge clk);
      #3;
      waited++;
    end
    last_wait = waited;
    chk("byte_accepted", {31'd0, bus.clr_rdy}, 32'd1);
    @(posedge clk);
    #1;
    bus.rx_rdy = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] s;
    s = b0 + b1 + b2;
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(~s);
`else
    s = ~s;
`endif
  endtask

  task automatic clear_cmd();
    bus.clr_cmd_rdy = 1'b1;
    cyc(1);
    bus.clr_cmd_rdy = 1'b0;
    #2;
    chk("cmd_rdy_cleared", {31'd0, bus.cmd_rdy}, 32'd0);
  endtask

  initial begin
    int base_clr;
    int base_to;

    rst_n           = 1'b0;
    bus.rx_data     = 8'h00;
    bus.rx_rdy      = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    cyc(3);
    #2;
    chk("rst_cmd", {8'd0, bus.cmd}, 32'h0);
    chk("rst_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
    chk("rst_clr_rdy", {31'd0, bus.clr_rdy}, 32'd0);
    chk("rst_to_err", {31'd0, bus.to_err}, 32'd0);
    chk("rst_chk_err", {31'd0, bus.chk_err}, 32'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    // Spaced bytes A5 12 34.
    base_clr = n_clr;
    send_byte(8'hA5);
    cyc(430);
    send_byte(8'h12);
    #2;
    chk("t1_not_ready_early", {31'd0, bus.cmd_rdy}, 32'd0);
    cyc(430);
    send_byte(8'h34);
    chk("t1_clr_pulses", n_clr - base_clr, 32'd3);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h14);
`endif
    #2;
    chk("t1_cmd", {8'd0, bus.cmd}, 32'h00A51234);
    chk("t1_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
    chk("t1_to_err", {31'd0, bus.to_err}, 32'd0);

    // Backpressure while held, then release.
    bus.rx_data = 8'h01;
    bus.rx_rdy  = 1'b1;
    base_clr    = n_clr;
    cyc(20);
    #2;
    chk("t2_hold_clr_rdy", {31'd0, bus.clr_rdy}, 32'd0);
    chk("t2_hold_no_pulses", n_clr - base_clr, 32'd0);
    chk("t2_hold_cmd", {8'd0, bus.cmd}, 32'h00A51234);
    chk("t2_hold_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
    bus.clr_cmd_rdy = 1'b1;
    #1;
    chk("t2_ack_cycle_clr_rdy", {31'd0, bus.clr_rdy}, 32'd0);
    cyc(1);
    bus.clr_cmd_rdy = 1'b0;
    #2;
    chk("t2_cmd_rdy_dropped", {31'd0, bus.cmd_rdy}, 32'd0);
    chk("t2_next_accept", {31'd0, bus.clr_rdy}, 32'd1);
    chk("t2_cmd_kept", {8'd0, bus.cmd}, 32'h00A51234);
    cyc(1);
    bus.rx_rdy = 1'b0;
    send_byte(8'hBB);
    send_byte(8'hCC);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h77);
`endif
    #2;
    chk("t2_cmd", {8'd0, bus.cmd}, 32'h0001BBCC);
    chk("t2_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
    clear_cmd();

    // Inter-byte timeout.
    base_to = n_to;
    send_byte(8'h07);
    send_byte(8'h08);
    cyc(4094);
    #2;
    chk("t3_no_early_to_a", {31'd0, bus.to_err}, 32'd0);
    cyc(1);
    #2;
    chk("t3_no_early_to_b", {31'd0, bus.to_err}, 32'd0);
    cyc(1);
    #2;
    chk("t3_to_err_pulse", {31'd0, bus.to_err}, 32'd1);
    cyc(1);
    #2;
    chk("t3_to_err_one_cycle", {31'd0, bus.to_err}, 32'd0);
    chk("t3_to_pulse_count", n_to - base_to, 32'd1);
    chk("t3_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
    chk("t3_cmd_kept", {8'd0, bus.cmd}, 32'h0001BBCC);
    cyc(50);
    chk("t3_still_one_pulse", n_to - base_to, 32'd1);
    send_cmd(8'h01, 8'h02, 8'h03);
    #2;
    chk("t3_cmd", {8'd0, bus.cmd}, 32'h00010203);
    chk("t3_cmd_rdy_new", {31'd0, bus.cmd_rdy}, 32'd1);
    clear_cmd();

    // Reset mid-frame.
    base_to = n_to;
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n       = 1'b0;
    bus.rx_data = 8'h44;
    bus.rx_rdy  = 1'b1;
    #2;
    chk("t4_rst_cmd", {8'd0, bus.cmd}, 32'h0);
    chk("t4_rst_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
    chk("t4_rst_clr_rdy", {31'd0, bus.clr_rdy}, 32'd0);
    chk("t4_rst_to_err", {31'd0, bus.to_err}, 32'd0);
    cyc(2);
    rst_n = 1'b1;
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h00);
`endif
    #2;
    chk("t4_cmd", {8'd0, bus.cmd}, 32'h00445566);
    chk("t4_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
    chk("t4_no_to_err", n_to - base_to, 32'd0);
    clear_cmd();

    // Byte lands in the cycle the counter sits at TIMEOUT_CLKS-1.
    base_to = n_to;
    send_byte(8'h77);
    cyc(TimeoutClks - 1);
    send_byte(8'h88);
    chk("t5_boundary_no_wait", last_wait, 32'd0);
    cyc(3);
    #2;
    chk("t5_no_to_err", n_to - base_to, 32'd0);
    send_byte(8'h99);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h67);
`endif
    #2;
    chk("t5_cmd", {8'd0, bus.cmd}, 32'h00778899);
    chk("t5_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
    clear_cmd();

`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    send_byte(8'h9F);
    #2;
    chk("cs_good_cmd", {8'd0, bus.cmd}, 32'h00102030);
    chk("cs_good_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
    clear_cmd();
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    send_byte(8'h00);
    #2;
    chk("cs_bad_chk_err", {31'd0, bus.chk_err}, 32'd1);
    chk("cs_bad_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
    chk("cs_bad_cmd_kept", {8'd0, bus.cmd}, 32'h00102030);
    cyc(1);
    #2;
    chk("cs_bad_one_cycle", {31'd0, bus.chk_err}, 32'd0);
    chk("cs_pulse_count", n_chk, 32'd1);
`else
    chk("no_chk_err", n_chk, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_seq.md
Name: uart_cmd_seq

Overview:
- Sequencer sitting between the UART receive datapath and the command decoder.
- Consumes received bytes over the receiver's rdy/clr_rdy handshake and assembles them into fixed-length commands: opcode byte, then high data byte, then low data byte.
- Presents each completed command to the decoder over a cmd_rdy/clr_cmd_rdy handshake.
- Discards partial frames on an inter-byte timeout and applies backpressure while a command is pending.

Parameters:
- TIMEOUT_CLKS, 4096: clocks allowed between accepted bytes of one frame before the partial frame is discarded; must be >= 2.
- TO_W, $clog2(TIMEOUT_CLKS): width of the timeout counter. Derived; do not override.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  byte from UART receiver; valid while rx_rdy=1
- rx_rdy  input  1  receiver byte-available flag (level; stays high until cleared)
- clr_rdy  output  1  one-cycle clear to the receiver's rdy flag
- cmd  output  24  assembled command: {opcode, data_hi, data_lo}
- cmd_rdy  output  1  command valid; held until clr_cmd_rdy
- clr_cmd_rdy  input  1  decoder acknowledges and consumes cmd
- to_err  output  1  one-cycle pulse: partial frame discarded on timeout
- chk_err  output  1  one-cycle pulse: checksum mismatch (0 unless CHECKSUM_EN)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; byte count=0; timeout counter=0.
  - cmd=24'h0; cmd_rdy=0; clr_rdy=0; to_err=0; chk_err=0.
  - Reset mid-frame drops the partial frame. No error pulse is generated.
- States: IDLE, COLLECT, HOLD.
- Byte accept:
  - In IDLE or COLLECT with rx_rdy=1, the byte is accepted that cycle.
  - clr_rdy is combinational and equals the accept strobe. It is high only in the accept cycle.
  - The byte is shifted into the frame register on the same edge.
  - The receiver's rdy drops the next cycle, so one byte is never accepted twice.
- IDLE:
  - On accept: byte count=1, timeout counter=0, go to COLLECT.
- COLLECT:
  - Timeout counter increments every cycle without an accept. Each accept resets it to 0.
  - On an accept that completes the frame (3rd byte): cmd is loaded with the frame, cmd_rdy=1 at the next edge, go to HOLD.
  - On any other accept: byte count increments.
  - If the counter reaches TIMEOUT_CLKS-1 with no accept that cycle: go to IDLE, byte count=0, to_err pulses high for exactly 1 cycle (registered, following the edge).
  - Accept and timeout in the same cycle: the accept wins; no error.
- HOLD:
  - clr_rdy is held 0. Receiver bytes wait in the receiver (backpressure).
  - cmd is stable while cmd_rdy=1.
  - clr_cmd_rdy=1: cmd_rdy=0 at the next edge, go to IDLE. A pending rx byte is accepted no earlier than the cycle after.
  - clr_cmd_rdy outside HOLD is ignored.
- cmd holds its last value after clear. It changes only when a new frame completes.
- Timeout counter saturates and never wraps. It is inactive in IDLE and HOLD.
- Latency:
  - Last byte accept to cmd_rdy high: 1 clk.
  - clr_cmd_rdy to next possible accept: 1 clk.

Optional Feature:
- Macro: UART_CMD_CHECKSUM_EN.
- Defined:
  - Frame is 4 bytes; the 4th is the checksum.
  - Valid when byte3 == ~(b0+b1+b2) mod 256.
  - Valid: behaves as a normal completion; cmd is taken from b0..b2.
  - Mismatch: frame discarded, go to IDLE, cmd and cmd_rdy unchanged, chk_err pulses 1 cycle.
  - The timeout applies across all 4 bytes.
- Undefined:
  - Frame is 3 bytes; chk_err is tied to 0.

Test Plan:
- Bytes 8'hA5, 8'h12, 8'h34 spaced 430 clks -> clr_rdy pulses once per byte; cmd=24'hA51234 and cmd_rdy=1 one clk after 3rd accept; to_err=0.
- Hold clr_cmd_rdy=0 while a 4th byte 8'h01 arrives -> clr_rdy stays 0 and cmd stays 24'hA51234; assert clr_cmd_rdy -> cmd_rdy=0 next clk, byte 8'h01 accepted the following clk.
- Bytes 8'h07, 8'h08, then silence >= TIMEOUT_CLKS -> exactly one to_err pulse at count 4095; cmd_rdy stays 0; new frame 8'h01, 8'h02, 8'h03 -> cmd=24'h010203.
- rst_n pulsed low after 2 bytes of a frame -> all outputs 0 immediately; next 3 bytes form a clean command; no to_err.
- Byte arriving in the same cycle the timeout counter hits TIMEOUT_CLKS-1 -> byte accepted, no to_err.
- CHECKSUM_EN: 8'h10, 8'h20, 8'h30, 8'h9F -> cmd=24'h102030; same frame with 8'h00 checksum -> chk_err pulse, cmd_rdy=0.
